// File: rtl/display_scheduler.sv
// Time/date view scheduler and 8-digit multiplexed scan driver with change blanking.
// Define DISP_AUTO_ROTATE_EN for automatic time/date rotation and manual-view timeout.
module display_scheduler #(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned TIME_SECS = 10,
  parameter int unsigned DATE_SECS = 3,
  parameter int unsigned HOLD_SECS = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick_1hz,
  input  logic        key_mode,
  input  logic [39:0] seg_word,
  output logic        display_year,
  output logic [7:0]  digit_sel,
  output logic [3:0]  digit_code,
  output logic        digit_dp
);

  localparam int unsigned PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);

`ifdef DISP_AUTO_ROTATE_EN
  typedef enum logic [1:0] {AUTO_TIME, AUTO_DATE, MAN_TIME, MAN_DATE} view_e;
  localparam view_e RST_VIEW = AUTO_TIME;
  logic [7:0] dwell_q, dwell_d, dwell_inc;
`else
  typedef enum logic [0:0] {MAN_TIME, MAN_DATE} view_e;
  localparam view_e RST_VIEW = MAN_TIME;
  logic unused_tick;
  assign unused_tick = tick_1hz;
`endif

  view_e         state_q, state_d;
  logic          year_q, year_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [2:0]    idx_q, idx_d;
  logic [1:0]    blank_q, blank_d;
  logic [7:0]    sel_q, sel_d;
  logic [3:0]    code_q, code_d;
  logic          dp_q, dp_d;
  logic [31:0]   digits;

  assign digits = seg_word[39:8];

  // View FSM: a key press always flips the shown view and wins over a coincident tick.
  always_comb begin
    state_d = state_q;
`ifdef DISP_AUTO_ROTATE_EN
    dwell_inc = dwell_q + 8'(tick_1hz);
    dwell_d   = dwell_q;
    if (key_mode) begin
      case (state_q)
        AUTO_TIME, MAN_TIME: state_d = MAN_DATE;
        default:             state_d = MAN_TIME;
      endcase
    end else begin
      dwell_d = dwell_inc;
      case (state_q)
        AUTO_TIME: if (tick_1hz && dwell_inc == 8'(TIME_SECS)) state_d = AUTO_DATE;
        AUTO_DATE: if (tick_1hz && dwell_inc == 8'(DATE_SECS)) state_d = AUTO_TIME;
        default:   if (tick_1hz && dwell_inc == 8'(HOLD_SECS)) state_d = AUTO_TIME;
      endcase
    end
    if (state_d != state_q) dwell_d = '0;
    year_d = (state_d == AUTO_DATE) || (state_d == MAN_DATE);
`else
    if (key_mode) state_d = (state_q == MAN_TIME) ? MAN_DATE : MAN_TIME;
    year_d = (state_d == MAN_DATE);
`endif
  end

  // Blanking is keyed off the next view so digit_sel goes dark on the same edge as display_year.
  always_comb begin
    pre_d = (pre_q == PRE_MAX) ? '0 : pre_q + 1'b1;
    idx_d = (pre_q == PRE_MAX) ? idx_q + 3'd1 : idx_q;
    if (year_d != year_q)  blank_d = 2'd2;
    else if (blank_q != '0) blank_d = blank_q - 2'd1;
    else                    blank_d = '0;
    if (blank_d != '0) begin
      sel_d  = '1;
      code_d = code_q;
      dp_d   = dp_q;
    end else begin
      sel_d  = ~(8'h01 << idx_q);
      code_d = digits[{idx_q, 2'b00} +: 4];
      dp_d   = seg_word[idx_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RST_VIEW;
`ifdef DISP_AUTO_ROTATE_EN
      dwell_q <= '0;
`endif
      year_q  <= 1'b0;
      pre_q   <= '0;
      idx_q   <= '0;
      blank_q <= '0;
      sel_q   <= '1;
      code_q  <= '0;
      dp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
`ifdef DISP_AUTO_ROTATE_EN
      dwell_q <= dwell_d;
`endif
      year_q  <= year_d;
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      blank_q <= blank_d;
      sel_q   <= sel_d;
      code_q  <= code_d;
      dp_q    <= dp_d;
    end
  end

  assign display_year = year_q;
  assign digit_sel    = sel_q;
  assign digit_code   = code_q;
  assign digit_dp     = dp_q;

endmodule
